// File: rtl/hash_multi_engine.sv
// Pops keys and lengths from upstream FIFOs, masks each key to its valid bytes, computes
// NUM_HASH seeded hashes and queues the packed word in an internal output FIFO.
module hash_multi_engine #(
  parameter int          KEY_W     = 128,
  parameter int          NUM_HASH  = 3,
  parameter int          HASH_W    = 20,
  parameter logic [31:0] SEED_BASE = 32'h0000_0000,
  parameter int          OUT_DEPTH = 16,
  parameter int          DROP_W    = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  iRdKeyEmpty,
  input  logic                                  iRdKeyLenEmpty,
  output logic                                  oRdKeyFifo_en,
  output logic                                  oRdKeyLenFifo_en,
  input  logic [KEY_W-1:0]                      iKey,
  input  logic [7:0]                            iKeyLen,
  input  logic                                  iRdHashFifo_en,
  output logic                                  oRdHashEmpty,
  output logic [NUM_HASH*HASH_W-1:0]            oKeyHashFifo,
  output logic [$clog2(OUT_DEPTH):0]            oHashCount,
  output logic [DROP_W-1:0]                     oDropCnt,
  output logic                                  oBusy
);

  localparam int AW    = $clog2(OUT_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int OUT_W = NUM_HASH * HASH_W;
  localparam int KB    = KEY_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_POP, S_CAPT, S_HASH} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [KEY_W-1:0]  r_key_p0;
  logic              r_len_zero_p0;
  logic [OUT_W-1:0]  w_word;
  logic              w_wr;
  logic              w_drop;
  logic              w_rd;
  logic [OUT_W-1:0]  r_mem [OUT_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_empty;
  logic [OUT_W-1:0]  r_dout;
  logic [DROP_W-1:0] r_drop;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
    int k;
    k = n % 32;
    if (k == 0) return x;
    return (x << k) | (x >> (32 - k));
  endfunction

  // Bytes at or beyond the length are cleared; lengths past KB keep the whole key.
  function automatic logic [KEY_W-1:0] mask_key(input logic [KEY_W-1:0] key,
                                                input logic [7:0] len);
    logic [KEY_W-1:0] m;
    m = '0;
    for (int b = 0; b < KB; b++)
      m[b*8 +: 8] = (b < int'(len)) ? key[b*8 +: 8] : 8'h00;
    return m;
  endfunction

  function automatic logic [OUT_W-1:0] pack_hash(input logic [KEY_W-1:0] key);
    logic [31:0]      f;
    logic [31:0]      s;
    logic [31:0]      r;
    logic [OUT_W-1:0] w;
    f = '0;
    for (int k = 0; k < KEY_W / 32; k++)
      f = f ^ key[k*32 +: 32];
    w = '0;
    for (int i = 0; i < NUM_HASH; i++) begin
      s = SEED_BASE + 32'(i) * 32'h9E37_79B9;
      r = rotl32(f ^ s, i);
      w[(NUM_HASH-1-i)*HASH_W +: HASH_W] = r[HASH_W-1:0];
    end
    return w;
  endfunction

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (!iRdKeyEmpty && !iRdKeyLenEmpty && (r_count != CNT_W'(OUT_DEPTH)))
                w_next = S_POP;
      S_POP:  w_next = S_CAPT;
      S_CAPT: w_next = S_HASH;
      S_HASH: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    oRdKeyFifo_en    = (r_state == S_POP);
    oRdKeyLenFifo_en = (r_state == S_POP);
    oBusy            = (r_state != S_IDLE);
  end

  // Capture stage: upstream data is valid the cycle after the pop.
  always_ff @(posedge clk) begin
    if (r_state == S_CAPT) begin
      r_key_p0      <= mask_key(iKey, iKeyLen);
      r_len_zero_p0 <= (iKeyLen == 8'd0);
    end
  end

  // Hash stage: write or drop, never both.
  assign w_word = pack_hash(r_key_p0);
  assign w_wr   = (r_state == S_HASH) && !r_len_zero_p0;
  assign w_drop = (r_state == S_HASH) &&  r_len_zero_p0;
  assign w_rd   = iRdHashFifo_en && !r_empty;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_dout   <= '0;
      r_drop   <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_dout   <= r_mem[r_rd_ptr];
      end
      case ({w_wr, w_rd})
        2'b10: begin
          r_count <= r_count + CNT_W'(1);
          r_empty <= 1'b0;
        end
        2'b01: begin
          r_count <= r_count - CNT_W'(1);
          r_empty <= (r_count == CNT_W'(1));
        end
        default: ;
      endcase
      if (w_drop) r_drop <= sat_inc(r_drop);
    end
  end

  assign oRdHashEmpty = r_empty;
  assign oKeyHashFifo = r_dout;
  assign oHashCount   = r_count;
  assign oDropCnt     = r_drop;

endmodule

// File: tb/tb_hash_multi_engine.sv
// Bench for hash_multi_engine: upstream FIFO model, hand vectors, corner sequences, random traffic.
module tb_hash_multi_engine;

  localparam int KEY_W = 128;
  localparam int NH    = 3;
  localparam int HW    = 20;
  localparam int OUT_W = NH * HW;
  localparam int DEPTH = 4;
  localparam int DW    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             iRdKeyEmpty;
  logic             iRdKeyLenEmpty;
  logic             oRdKeyFifo_en;
  logic             oRdKeyLenFifo_en;
  logic [KEY_W-1:0] iKey;
  logic [7:0]       iKeyLen;
  logic             iRdHashFifo_en;
  logic             oRdHashEmpty;
  logic [OUT_W-1:0] oKeyHashFifo;
  logic [2:0]       oHashCount;
  logic [DW-1:0]    oDropCnt;
  logic             oBusy;

  hash_multi_engine #(
    .KEY_W(KEY_W), .NUM_HASH(NH), .HASH_W(HW), .SEED_BASE(32'h0),
    .OUT_DEPTH(DEPTH), .DROP_W(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .iRdKeyEmpty(iRdKeyEmpty), .iRdKeyLenEmpty(iRdKeyLenEmpty),
    .oRdKeyFifo_en(oRdKeyFifo_en), .oRdKeyLenFifo_en(oRdKeyLenFifo_en),
    .iKey(iKey), .iKeyLen(iKeyLen),
    .iRdHashFifo_en(iRdHashFifo_en), .oRdHashEmpty(oRdHashEmpty),
    .oKeyHashFifo(oKeyHashFifo), .oHashCount(oHashCount),
    .oDropCnt(oDropCnt), .oBusy(oBusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [KEY_W-1:0] key;
    logic [7:0]       len;
    logic [OUT_W-1:0] exp;
  } vec_t;

  vec_t             vecs [5];
  logic [KEY_W-1:0] key_q [$];
  logic [7:0]       len_q [$];
  logic [OUT_W-1:0] exp_q [$];
  int               exp_drops = 0;
  int               pops      = 0;
  int               split_err = 0;
  int               n_checks  = 0;
  int               n_pass    = 0;

  // Spec-level hash: mask by length, fold words, seeded rotate, H0 ends up in the MSBs.
  function automatic logic [OUT_W-1:0] ref_hash(input logic [KEY_W-1:0] key, input int len);
    int               l;
    logic [KEY_W-1:0] mk;
    logic [31:0]      f;
    logic [31:0]      x;
    logic [63:0]      dbl;
    logic [OUT_W-1:0] w;
    l  = (len > 16) ? 16 : len;
    mk = (l == 16) ? key : (key & ((128'h1 << (8 * l)) - 128'h1));
    f  = 32'h0;
    for (int k = 0; k < 4; k++) f = f ^ mk[32*k +: 32];
    w = '0;
    for (int i = 0; i < NH; i++) begin
      x   = f ^ (32'h0 + 32'(i) * 32'h9E3779B9);
      dbl = {x, x} << i;
      w   = {w[OUT_W-HW-1:0], dbl[51:32]};
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One clock; also plays the upstream FIFOs (data appears the cycle after the read enable).
  task automatic tick();
    logic pop;
    pop = oRdKeyFifo_en;
    if (oRdKeyFifo_en !== oRdKeyLenFifo_en) split_err++;
    @(posedge clk);
    #1;
    if (pop) begin
      pops++;
      if (key_q.size() > 0) begin
        iKey    = key_q.pop_front();
        iKeyLen = len_q.pop_front();
      end
      iRdKeyEmpty    = (key_q.size() == 0);
      iRdKeyLenEmpty = (len_q.size() == 0);
    end
  endtask

  task automatic push_key(input logic [KEY_W-1:0] k, input logic [7:0] l);
    key_q.push_back(k);
    len_q.push_back(l);
    iRdKeyEmpty    = 1'b0;
    iRdKeyLenEmpty = 1'b0;
    if (l == 8'd0) exp_drops++;
    else exp_q.push_back(ref_hash(k, int'(l)));
  endtask

  task automatic wait_nonempty(input string name);
    int g;
    g = 0;
    while (oRdHashEmpty && g < 50) begin
      tick();
      g++;
    end
    if (oRdHashEmpty) chk({name, "_timeout"}, oRdHashEmpty, 1'b0);
  endtask

  task automatic read_word(output logic [OUT_W-1:0] w);
    iRdHashFifo_en = 1'b1;
    tick();
    iRdHashFifo_en = 1'b0;
    w = oKeyHashFifo;
  endtask

  task automatic read_check(input string name);
    logic [OUT_W-1:0] w;
    read_word(w);
    if (exp_q.size() == 0) chk({name, "_unexpected"}, w, 'x);
    else chk(name, w, exp_q.pop_front());
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 400) begin
      if (!oRdHashEmpty) read_check(name);
      else tick();
      g++;
    end
    chk({name, "_left"}, exp_q.size(), 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
    exp_q.delete();
    exp_drops = 0;
  endtask

  initial begin
    logic [OUT_W-1:0] w;
    int               p0;
    int               r;

    rst = 1'b1; iRdKeyEmpty = 1'b1; iRdKeyLenEmpty = 1'b1;
    iKey = '0; iKeyLen = '0; iRdHashFifo_en = 1'b0;

    vecs[0] = '{128'h1, 8'd1, {20'h00001, 20'hEF371, 20'hBCDCC}};
    vecs[1] = '{{16{8'hFF}}, 8'd2, {20'h0FFFF, 20'hF0C8D, 20'h83234}};
    vecs[2] = '{128'hFFFF, 8'd2, {20'h0FFFF, 20'hF0C8D, 20'h83234}};
    vecs[3] = '{{16{8'hFF}}, 8'd200, {20'h00000, 20'hEF373, 20'hBCDC8}};
    vecs[4] = '{{16{8'hFF}}, 8'd16, {20'h00000, 20'hEF373, 20'hBCDC8}};

    // Reset then idle
    tick(); tick();
    chk("rst_key_en", oRdKeyFifo_en, 1'b0);
    chk("rst_len_en", oRdKeyLenFifo_en, 1'b0);
    chk("rst_empty", oRdHashEmpty, 1'b1);
    chk("rst_count", oHashCount, 3'd0);
    chk("rst_drop", oDropCnt, 2'd0);
    chk("rst_busy", oBusy, 1'b0);
    chk("rst_dout", oKeyHashFifo, '0);
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_no_pop", pops, 0);

    // Single key: pop timing and 4-cycle write latency
    push_key(128'h1, 8'd1);
    chk("single_en_before", oRdKeyFifo_en, 1'b0);
    tick();
    chk("single_key_en", oRdKeyFifo_en, 1'b1);
    chk("single_len_en", oRdKeyLenFifo_en, 1'b1);
    chk("single_busy", oBusy, 1'b1);
    tick();
    chk("single_en_one_cycle", oRdKeyFifo_en, 1'b0);
    tick();
    chk("single_count_early", oHashCount, 3'd0);
    tick();
    chk("single_count", oHashCount, 3'd1);
    chk("single_empty", oRdHashEmpty, 1'b0);
    read_word(w);
    chk("single_word", w, {20'h00001, 20'hEF371, 20'hBCDCC});
    void'(exp_q.pop_front());
    chk("single_count_after", oHashCount, 3'd0);

    // Hand vectors: masking and length saturation
    foreach (vecs[i]) begin
      push_key(vecs[i].key, vecs[i].len);
      wait_nonempty($sformatf("vec%0d", i));
      read_word(w);
      chk($sformatf("vec%0d_word", i), w, vecs[i].exp);
      void'(exp_q.pop_front());
    end

    // Zero-length keys are dropped; the counter saturates
    p0 = pops;
    repeat (3) push_key(128'hABCD, 8'd0);
    repeat (20) tick();
    chk("zero_pops", pops - p0, 3);
    chk("zero_drop3", oDropCnt, 2'd3);
    chk("zero_empty", oRdHashEmpty, 1'b1);
    repeat (2) push_key(128'h1234, 8'd0);
    repeat (15) tick();
    chk("zero_drop_sat", oDropCnt, 2'd3);
    chk("zero_count", oHashCount, 3'd0);

    // Backpressure with a full output FIFO
    p0 = pops;
    for (int i = 0; i < 6; i++)
      push_key({$urandom, $urandom, $urandom, $urandom}, 8'($urandom_range(1, 16)));
    repeat (40) tick();
    chk("bp_pops4", pops - p0, 4);
    chk("bp_count4", oHashCount, 3'd4);
    chk("bp_idle", oBusy, 1'b0);
    read_check("bp_word");
    repeat (10) tick();
    chk("bp_pops5", pops - p0, 5);
    chk("bp_count_refill", oHashCount, 3'd4);
    drain("bp_word");
    chk("bp_count0", oHashCount, 3'd0);

    // Read on the same edge as a write keeps the count
    push_key(128'h0123_4567_89AB_CDEF, 8'd8);
    wait_nonempty("rw_a");
    push_key(128'hDEAD_BEEF, 8'd3);
    tick(); tick(); tick();
    iRdHashFifo_en = 1'b1;
    tick();
    iRdHashFifo_en = 1'b0;
    chk("rw_count", oHashCount, 3'd1);
    chk("rw_word_a", oKeyHashFifo, exp_q.pop_front());
    read_check("rw_word_b");
    chk("rw_empty", oRdHashEmpty, 1'b1);

    // Reset while capturing discards the key
    push_key(128'h5555, 8'd2);
    tick(); tick();
    chk("rstcapt_busy_pre", oBusy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("rstcapt_busy", oBusy, 1'b0);
    chk("rstcapt_count", oHashCount, 3'd0);
    chk("rstcapt_dout", oKeyHashFifo, '0);
    repeat (8) tick();
    chk("rstcapt_no_write", oHashCount, 3'd0);
    chk("rstcapt_empty", oRdHashEmpty, 1'b1);

    // Random traffic against the reference model
    do_reset(2);
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 9);
        push_key({$urandom, $urandom, $urandom, $urandom},
                 (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(1, 16)));
      end
      if (!oRdHashEmpty && $urandom_range(0, 1) == 1) read_check("rand_word");
      else tick();
    end
    drain("rand_word");
    repeat (8) tick();
    chk("rand_count", oHashCount, 3'd0);
    chk("rand_drop", oDropCnt, (exp_drops > 3) ? 2'd3 : 2'(exp_drops));
    chk("enable_split", split_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
